// File: rtl/wb_dma_engine.sv
// wb_dma_engine: Wishbone-configured DMA engine that streams memory through an
// external processing element.
//
// For each word the engine reads memory at SRC, hands the word out on the
// stream-out port, takes the processed result back on the stream-in port,
// and writes it to memory at DST. The word counter alone ends the transfer.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*                Wishbone config slave (CTRL 0x00, SRC 0x04, DST 0x08, LEN 0x0C)
//   dma_*                Wishbone initiator used for memory reads and writes
//   ss_*                 stream-out (words read from memory)
//   sm_*                 stream-in (processed words to be written back)
//   irq_o                transfer-done interrupt
//   dbg_state            current FSM state (0 IDLE, 1 RD, 2 PUSH, 3 PULL, 4 WR, 5 DONE)
//
// CTRL reads {29'b0, busy, done, 1'b0}. Writing bit0=1 while idle with
// LEN in 1..MAX_LEN starts a transfer.
//
// Optional feature macro: DMA_IRQ_EN
//   defined   -> irq_o pulses for one cycle on DONE entry; CTRL bit3=1 clears done
//   undefined -> irq_o tied 0; done is cleared only by a new start
//
// Handshakes: stream beats transfer on a rising edge where valid and ready
// are both 1; tdata/tlast stay stable while valid is held without ready.
// Wishbone cycles complete on the rising edge where ack is 1, and the
// initiator keeps adr/dat/we/sel stable until then.
module wb_dma_engine #(
  parameter logic [31:0] CFG_BASE = 32'h3800_0000,
  parameter int          MAX_LEN  = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // config slave
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  // initiator
  output logic        dma_stb_o,
  output logic        dma_cyc_o,
  output logic        dma_we_o,
  output logic [3:0]  dma_sel_o,
  output logic [31:0] dma_adr_o,
  output logic [31:0] dma_dat_o,
  input  logic        dma_ack_i,
  input  logic [31:0] dma_dat_i,
  // stream out
  output logic        ss_tvalid,
  output logic        ss_tlast,
  output logic [31:0] ss_tdata,
  input  logic        ss_tready,
  // stream in
  input  logic        sm_tvalid,
  input  logic        sm_tlast,
  input  logic [31:0] sm_tdata,
  output logic        sm_tready,
  // status
  output logic        irq_o,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_PUSH = 3'd2,
    S_PULL = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

  state_t      state, state_nxt;

  logic [31:0] src_reg, dst_reg;
  logic [9:0]  len_reg;
  logic [31:0] src_cnt, dst_cnt;
  logic [9:0]  word_cnt;
  logic [31:0] rd_word, wr_word;
  logic        done;

  logic        busy, last_word, len_ok;
  logic        cfg_hit, cfg_acc, cfg_wr, start_req;
  logic [31:0] rd_mux, wdat_merged_src, wdat_merged_dst, wdat_merged_len;

  // sm_tlast carries no meaning here: the word counter ends the transfer.
  logic        unused_sm_tlast;
  assign unused_sm_tlast = sm_tlast;

  // Byte-lane merge for config writes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  assign busy      = (state != S_IDLE);
  assign last_word = (word_cnt == len_reg - 10'd1);
  assign len_ok    = (len_reg != 10'd0) && (len_reg <= MAX_LEN_W);

  // Accept an access only in the cycle before ack. This gives a one-cycle ack
  // and a forced low cycle before the next one, even if stb stays high.
  assign cfg_hit   = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == CFG_BASE[31:8]);
  assign cfg_acc   = cfg_hit && !wbs_ack_o;
  assign cfg_wr    = cfg_acc && wbs_we_i;
  assign start_req = cfg_wr && (wbs_adr_i[7:0] == 8'h00) && wbs_sel_i[0] &&
                     wbs_dat_i[0] && !busy && len_ok;

  assign wdat_merged_src = merge_bytes(src_reg, wbs_dat_i, wbs_sel_i);
  assign wdat_merged_dst = merge_bytes(dst_reg, wbs_dat_i, wbs_sel_i);
  assign wdat_merged_len = merge_bytes({22'b0, len_reg}, wbs_dat_i, wbs_sel_i);

  always_comb begin
    rd_mux = 32'h0;
    case (wbs_adr_i[7:0])
      8'h00:   rd_mux = {29'b0, busy, done, 1'b0};
      8'h04:   rd_mux = src_reg;
      8'h08:   rd_mux = dst_reg;
      8'h0C:   rd_mux = {22'b0, len_reg};
      default: rd_mux = 32'h0;
    endcase
  end

  // Config slave response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= cfg_acc;
      wbs_dat_o <= cfg_acc ? rd_mux : 32'h0;
    end
  end

  // FSM: state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_RD;
      S_RD:    if (dma_ack_i) state_nxt = S_PUSH;
      S_PUSH:  if (ss_tready) state_nxt = S_PULL;
      S_PULL:  if (sm_tvalid) state_nxt = S_WR;
      S_WR:    if (dma_ack_i) state_nxt = last_word ? S_DONE : S_RD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything idles at 0 outside the states that drive it.
  always_comb begin
    dma_cyc_o = 1'b0;
    dma_stb_o = 1'b0;
    dma_we_o  = 1'b0;
    dma_sel_o = 4'h0;
    dma_adr_o = 32'h0;
    dma_dat_o = 32'h0;
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    ss_tdata  = 32'h0;
    sm_tready = 1'b0;
    irq_o     = 1'b0;
    case (state)
      S_RD: begin
        dma_cyc_o = 1'b1;
        dma_stb_o = 1'b1;
        dma_sel_o = 4'hF;
        dma_adr_o = src_cnt;
      end
      S_PUSH: begin
        ss_tvalid = 1'b1;
        ss_tlast  = last_word;
        ss_tdata  = rd_word;
      end
      S_PULL: sm_tready = 1'b1;
      S_WR: begin
        dma_cyc_o = 1'b1;
        dma_stb_o = 1'b1;
        dma_we_o  = 1'b1;
        dma_sel_o = 4'hF;
        dma_adr_o = dst_cnt;
        dma_dat_o = wr_word;
      end
      S_DONE: begin
`ifdef DMA_IRQ_EN
        irq_o = 1'b1;
`else
        irq_o = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Config registers and transfer datapath.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      src_reg  <= 32'h0;
      dst_reg  <= 32'h0;
      len_reg  <= 10'd0;
      src_cnt  <= 32'h0;
      dst_cnt  <= 32'h0;
      word_cnt <= 10'd0;
      rd_word  <= 32'h0;
      wr_word  <= 32'h0;
      done     <= 1'b0;
    end else begin
      if (cfg_wr && !busy) begin
        case (wbs_adr_i[7:0])
          8'h04:   src_reg <= {wdat_merged_src[31:2], 2'b00};
          8'h08:   dst_reg <= {wdat_merged_dst[31:2], 2'b00};
          8'h0C:   len_reg <= wdat_merged_len[9:0];
          default: ;
        endcase
      end
`ifdef DMA_IRQ_EN
      if (cfg_wr && (wbs_adr_i[7:0] == 8'h00) && wbs_sel_i[0] && wbs_dat_i[3])
        done <= 1'b0;
`endif
      if (start_req) begin
        done     <= 1'b0;
        word_cnt <= 10'd0;
        src_cnt  <= src_reg;
        dst_cnt  <= dst_reg;
      end
      if (state == S_RD && dma_ack_i) begin
        rd_word <= dma_dat_i;
        src_cnt <= src_cnt + 32'd4;   // wraps modulo 2^32
      end
      if (state == S_PULL && sm_tvalid) wr_word <= sm_tdata;
      if (state == S_WR && dma_ack_i) begin
        dst_cnt  <= dst_cnt + 32'd4;
        word_cnt <= word_cnt + 10'd1;
        // Set here rather than in DONE so it wins over a same-cycle bit3 clear.
        if (last_word) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_dma_engine.sv
// Testbench for wb_dma_engine: randomized memory/stream responders with a
// transfer-level reference model (expected reads, stream beats and writes
// computed from SRC/DST/LEN and the memory contents).
module tb_wb_dma_engine;

  localparam logic [31:0] BASE = 32'h3800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dma_stb_o, dma_cyc_o, dma_we_o;
  logic [3:0]  dma_sel_o;
  logic [31:0] dma_adr_o, dma_dat_o;
  logic        dma_ack_i;
  logic [31:0] dma_dat_i;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;
  logic        irq_o;
  logic [2:0]  dbg_state;

  wb_dma_engine dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_stb_o(dma_stb_o), .dma_cyc_o(dma_cyc_o), .dma_we_o(dma_we_o),
    .dma_sel_o(dma_sel_o), .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o),
    .dma_ack_i(dma_ack_i), .dma_dat_i(dma_dat_i),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata), .sm_tready(sm_tready),
    .irq_o(irq_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd_q[$];   // read addresses
  logic [32:0] exp_ss_q[$];   // {tlast, tdata} stream-out beats
  logic [31:0] exp_wa_q[$];   // write addresses
  logic [31:0] exp_wd_q[$];   // write data (filled as the stream source hands words over)

  task automatic model_xfer(input logic [31:0] s, input logic [31:0] d, input int len);
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = (s & ~32'h3) + 32'(4 * i);
      mem[a] = $urandom;
      exp_rd_q.push_back(a);
      exp_ss_q.push_back({(i == len - 1), mem[a]});
      exp_wa_q.push_back((d & ~32'h3) + 32'(4 * i));
    end
  endtask

  task automatic flush_model();
    exp_rd_q.delete(); exp_ss_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
  endtask

  // Stimulus knobs.
  int ack_fixed = 0;     // <0: random 0..3 wait cycles
  int valid_pct = 100;
  bit stall10   = 1'b0;

  int bus_cycles = 0;
  int wr_acks    = 0;
  int irq_cnt    = 0;

  // ---------------- memory responder on the initiator port ----------------
  bit          bus_active = 1'b0;
  int          bus_wait;
  logic [31:0] h_adr, h_dat;
  logic        h_we;
  logic [3:0]  h_sel;

  always @(negedge clk) begin
    if (rst) begin
      dma_ack_i = 1'b0; dma_dat_i = 32'h0; bus_active = 1'b0;
    end else begin
      if (dma_ack_i) begin
        dma_ack_i = 1'b0; dma_dat_i = 32'h0; bus_active = 1'b0;
      end
      if (dma_stb_o && !dma_cyc_o) check("stb_without_cyc", 1, 0);
      if (dma_cyc_o && dma_stb_o) begin
        if (!bus_active) begin
          bus_active = 1'b1; bus_cycles++;
          h_adr = dma_adr_o; h_dat = dma_dat_o; h_we = dma_we_o; h_sel = dma_sel_o;
          bus_wait = (ack_fixed >= 0) ? ack_fixed : $urandom_range(0, 3);
        end else begin
          check("bus_hold", {dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o}, {h_we, h_sel, h_adr, h_dat});
        end
        if (bus_wait == 0) begin
          dma_ack_i = 1'b1;
          check("bus_sel", dma_sel_o, 4'hF);
          if (h_we) begin
            wr_acks++;
            if (exp_wa_q.size() == 0 || exp_wd_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
              check("wr_adr", h_adr, exp_wa_q.pop_front());
              check("wr_dat", h_dat, exp_wd_q.pop_front());
            end
          end else begin
            dma_dat_i = mem.exists(h_adr) ? mem[h_adr] : 32'h0;
            if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_adr", h_adr, exp_rd_q.pop_front());
          end
        end else begin
          bus_wait--;
        end
      end
    end
  end

  // ---------------- stream-out sink ----------------
  bit          ss_pend = 1'b0;
  logic [32:0] ss_hold;
  int          ss_stall;

  always @(negedge clk) begin
    if (rst) begin
      ss_tready = 1'b0; ss_pend = 1'b0; ss_stall = 0;
    end else if (ss_tvalid) begin
      if (ss_pend) check("ss_stable", {ss_tlast, ss_tdata}, ss_hold);
      else begin
        ss_pend = 1'b1; ss_hold = {ss_tlast, ss_tdata};
        ss_stall = stall10 ? 10 : $urandom_range(0, 2);
      end
      check("no_bus_in_push", dma_cyc_o, 0);
      if (ss_stall > 0) begin
        ss_tready = 1'b0; ss_stall--;
      end else begin
        ss_tready = 1'b1; ss_pend = 1'b0;
        if (exp_ss_q.size() == 0) check("ss_unexpected", 1, 0);
        else check("ss_beat", {ss_tlast, ss_tdata}, exp_ss_q.pop_front());
      end
    end else begin
      ss_tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stream-in source ----------------
  always @(negedge clk) begin
    if (rst || !sm_tready) begin
      sm_tvalid = 1'b0; sm_tdata = 32'h0; sm_tlast = 1'b0;
    end else begin
      sm_tvalid = ($urandom_range(0, 99) < valid_pct);
      if (sm_tvalid) begin
        sm_tdata = $urandom;
        sm_tlast = 1'($urandom_range(0, 1));   // meaningless to the engine
        exp_wd_q.push_back(sm_tdata);
      end
    end
  end

  // ---------------- passive monitors ----------------
  always @(negedge clk) begin
    if (irq_o) irq_cnt++;
    if (!rst && !wbs_ack_o) check("cfg_dat_idle", wbs_dat_o, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 8);
    check("cfg_ack_latency", n, 1);
    q = wbs_dat_o;
    @(negedge clk);
    check("cfg_ack_one_cycle", wbs_ack_o, 0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'h0, q);
  endtask

  task automatic program_regs(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    wb_write(BASE + 32'h4, s);
    wb_write(BASE + 32'h8, d);
    wb_write(BASE + 32'hC, l);
  endtask

  int xfers_done = 0;

  // Poll CTRL until idle, then check the model has been fully consumed.
  task automatic wait_idle();
    logic [31:0] q;
    int n = 0;
    do begin wb_read(BASE, q); n++; end while (q[2] && n < 300);
    check("xfer_finished", q[2], 0);
    check("ctrl_after_xfer", q, 32'h2);
    check("rd_left", exp_rd_q.size(), 0);
    check("ss_left", exp_ss_q.size(), 0);
    check("wr_left", exp_wa_q.size(), 0);
    check("wd_left", exp_wd_q.size(), 0);
    xfers_done++;
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int len);
    program_regs(s, d, 32'(len));
    model_xfer(s, d, len);
    wb_write(BASE, 32'h1);
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] q;
    int bc, ic;
    bit found;

    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    dma_ack_i = 0; dma_dat_i = 0; ss_tready = 0; sm_tvalid = 0; sm_tlast = 0; sm_tdata = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {dma_cyc_o, dma_stb_o, dma_we_o, ss_tvalid, sm_tready, irq_o, wbs_ack_o},
          7'b0);
    check("rst_buses", {dma_adr_o, dma_dat_o, ss_tdata}, 96'h0);
    rst = 1'b0;
    wb_read(BASE, q);        check("rst_ctrl", q, 0);
    wb_read(BASE + 4, q);    check("rst_src", q, 0);
    wb_read(BASE + 8, q);    check("rst_dst", q, 0);
    wb_read(BASE + 32'hC, q); check("rst_len", q, 0);

    // Register readback; SRC low bits are forced to 0, LEN is 10 bits.
    wb_write(BASE + 4, 32'h1234_5677);
    wb_read(BASE + 4, q);    check("src_align", q, 32'h1234_5674);
    wb_write(BASE + 32'hC, 32'hFFFF_F403);
    wb_read(BASE + 32'hC, q); check("len_10bit", q, 32'h3);

    // Directed three-word transfer.
    ack_fixed = 0; valid_pct = 100;
    program_regs(32'h40, 32'h200, 32'd3);
    model_xfer(32'h40, 32'h200, 3);
    wb_write(BASE, 32'h1);
    wb_read(BASE, q); check("busy_during_xfer", q[2], 1);
    wait_idle();

    // Illegal lengths: no bus activity, busy stays 0, done untouched.
    bc = bus_cycles;
    wb_write(BASE + 32'hC, 32'd0);    wb_write(BASE, 32'h1);
    repeat (5) @(negedge clk);
    wb_read(BASE, q); check("len0_ctrl", q, 32'h2);
    wb_write(BASE + 32'hC, 32'd1024); wb_write(BASE, 32'h1);
    repeat (5) @(negedge clk);
    wb_read(BASE, q); check("len1024_ctrl", q, 32'h2);
    check("illegal_len_no_bus", bus_cycles, bc);

    // Config writes and a second start while busy are ignored.
    ack_fixed = 2;
    program_regs(32'h1000, 32'h2000, 32'd3);
    model_xfer(32'h1000, 32'h2000, 3);
    wb_write(BASE, 32'h1);
    wb_write(BASE + 4, 32'hDEAD_BEE0);
    wb_write(BASE + 32'hC, 32'd5);
    wb_write(BASE, 32'h1);
    wait_idle();
    wb_read(BASE + 4, q);     check("src_busy_ignored", q, 32'h1000);
    wb_read(BASE + 32'hC, q); check("len_busy_ignored", q, 32'd3);

    // Stream-out stall of 10 cycles on every beat.
    ack_fixed = 0; stall10 = 1'b1;
    run_xfer(32'h300, 32'h400, 2);
    stall10 = 1'b0;

    // Five-cycle ack delay on every initiator cycle.
    ack_fixed = 5;
    run_xfer(32'h500, 32'h600, 2);

    // Single-word transfer: interrupt and done-clear behaviour.
    ack_fixed = 0;
    ic = irq_cnt;
    run_xfer(32'h700, 32'h800, 1);
    repeat (3) @(negedge clk);
    wb_write(BASE, 32'h8);
    wb_read(BASE, q);
`ifdef DMA_IRQ_EN
    check("irq_one_cycle", irq_cnt - ic, 1);
    check("done_cleared_bit3", q, 32'h0);
`else
    check("irq_tied_low", irq_cnt - ic, 0);
    check("done_kept_bit3", q, 32'h2);
`endif

    // Randomized transfers, plus one that wraps both address counters.
    ack_fixed = -1;
    for (int t = 0; t < 6; t++) begin
      valid_pct = $urandom_range(30, 100);
      run_xfer($urandom, $urandom, $urandom_range(1, 6));
    end
    run_xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3);

    // Reset during the write of word 2 of 4.
    ack_fixed = 8; valid_pct = 100;
    ic = irq_cnt;
    program_regs(32'h900, 32'hA00, 32'd4);
    model_xfer(32'h900, 32'hA00, 4);
    wb_write(BASE, 32'h1);
    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      if (dma_cyc_o && dma_we_o && dma_adr_o == 32'hA04) found = 1'b1;
    end
    check("reached_wr_word2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {dma_cyc_o, dma_stb_o, ss_tvalid, sm_tready, irq_o}, 5'b0);
    rst = 1'b0;
    flush_model();
    bc = bus_cycles;
    repeat (20) @(negedge clk);
    check("midrst_no_retry", bus_cycles, bc);
    wb_read(BASE, q);     check("midrst_ctrl", q, 0);
    wb_read(BASE + 4, q); check("midrst_src", q, 0);
    check("midrst_no_irq", irq_cnt, ic);

`ifdef DMA_IRQ_EN
    check("irq_total", irq_cnt, xfers_done);
`else
    check("irq_total", irq_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
